// File: rtl/serial_to_parallel_if.sv
// Bundle of the serial-link input side and the parallel valid/ready output
// side of the serial_to_parallel receiver, plus its status flags.
interface serial_to_parallel_if #(
  parameter int DATA_LEN = 8
);
  logic                serial_in;
  logic                serial_valid;
  logic                frame_start;
  logic [DATA_LEN-1:0] parallel_out;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                frame_err;
  logic                overrun;

  // Producer of serial bits and consumer of parallel words
  modport master (
    output serial_in,
    output serial_valid,
    output frame_start,
    output out_ready,
    input  parallel_out,
    input  out_valid,
    input  busy,
    input  frame_err,
    input  overrun
  );

  // The receiver itself
  modport slave (
    input  serial_in,
    input  serial_valid,
    input  frame_start,
    input  out_ready,
    output parallel_out,
    output out_valid,
    output busy,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: collects LSB-first frames of DATA_LEN bits,
// presents each completed word on a valid/ready port, and flags mid-frame
// resyncs (frame_err pulse) and dropped words (sticky overrun).
module serial_to_parallel #(
  parameter int DATA_LEN = 8
) (
  input logic                clk,
  input logic                rst,
  serial_to_parallel_if.slave bus
);

  localparam int CW = $clog2(DATA_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_LEN - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Only DATA_LEN-1 bits are ever held: the final bit of a frame is taken
  // straight from serial_in when the word is assembled.
  logic [0:0]          state;
  logic [DATA_LEN-2:0] shreg;
  logic [CW-1:0]       bit_cnt;

  logic [DATA_LEN-1:0] shifted;
  logic [DATA_LEN-2:0] fresh;
  logic                start_bit;
  logic                resync;
  logic                word_done;

  logic [DATA_LEN-1:0] out_word;
  logic                out_valid_r;
  logic                frame_err_r;
  logic                overrun_r;

  // Decode this cycle's bit: shifted view, new-frame seed, and completion
  always_comb begin
    shifted   = {bus.serial_in, shreg};
    fresh     = '0;
    fresh[DATA_LEN-2] = bus.serial_in;
    start_bit = bus.serial_valid && bus.frame_start;
    resync    = start_bit && (state == ST_SHIFT);
    word_done = bus.serial_valid && !bus.frame_start &&
                (state == ST_SHIFT) && (bit_cnt == LAST_CNT);
  end

  // Frame assembly FSM: shift register, bit counter and resync pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= resync;
      if (start_bit) begin
        shreg   <= fresh;
        bit_cnt <= CW'(1);
        state   <= ST_SHIFT;
      end else if (bus.serial_valid && (state == ST_SHIFT)) begin
        shreg <= shifted[DATA_LEN-1:1];
        if (word_done) begin
          bit_cnt <= '0;
          state   <= ST_IDLE;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      out_word    <= '0;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (word_done) begin
      if (!out_valid_r || bus.out_ready) begin
        out_word    <= shifted;
        out_valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.parallel_out = out_word;
  assign bus.out_valid    = out_valid_r;
  assign bus.busy         = (state == ST_SHIFT);
  assign bus.frame_err    = frame_err_r;
  assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Testbench for serial_to_parallel: directed scenarios followed by random
// traffic, every cycle compared against a bit-indexed reference model.
module tb_serial_to_parallel;

  localparam int DATA_LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_to_parallel_if #(.DATA_LEN(DATA_LEN)) bus();

  serial_to_parallel #(.DATA_LEN(DATA_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DATA_LEN-1:0] m_acc;
  logic [DATA_LEN-1:0] m_out;
  int                  m_idx;
  logic                m_busy;
  logic                m_valid;
  logic                m_ferr;
  logic                m_over;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a frame is a list of bits written by index; a word exists
  // once index DATA_LEN-1 has been filled without an intervening frame_start.
  task automatic modelEdge(input logic r, input logic sv, input logic si,
                           input logic fs, input logic rdy);
    logic                done;
    logic                consume;
    logic [DATA_LEN-1:0] word;
    done    = 1'b0;
    word    = '0;
    consume = m_valid && rdy;
    if (r) begin
      m_acc = '0; m_out = '0; m_idx = 0;
      m_busy = 1'b0; m_valid = 1'b0; m_ferr = 1'b0; m_over = 1'b0;
    end else begin
      m_ferr = 1'b0;
      if (sv && fs) begin
        if (m_busy) m_ferr = 1'b1;
        m_acc    = '0;
        m_acc[0] = si;
        m_idx    = 1;
        m_busy   = 1'b1;
      end else if (sv && m_busy) begin
        m_acc[m_idx] = si;
        m_idx++;
        if (m_idx == DATA_LEN) begin
          done   = 1'b1;
          word   = m_acc;
          m_busy = 1'b0;
          m_idx  = 0;
        end
      end
      if (done) begin
        if (!m_valid || consume) begin
          m_out   = word;
          m_valid = 1'b1;
        end else begin
          m_over = 1'b1;
        end
      end else if (consume) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("parallel_out", 64'(bus.parallel_out), 64'(m_out));
    checkValue("out_valid",    64'(bus.out_valid),    64'(m_valid));
    checkValue("busy",         64'(bus.busy),         64'(m_busy));
    checkValue("frame_err",    64'(bus.frame_err),    64'(m_ferr));
    checkValue("overrun",      64'(bus.overrun),      64'(m_over));
  endtask

  task automatic applyStimulus(input logic sv, input logic si, input logic fs, input logic rdy);
    bus.serial_valid = sv;
    bus.serial_in    = si;
    bus.frame_start  = fs;
    bus.out_ready    = rdy;
    @(posedge clk);
    modelEdge(rst, sv, si, fs, rdy);
    #1;
    checkOutput();
  endtask

  task automatic sendWord(input logic [DATA_LEN-1:0] w, input logic rdy_mid, input logic rdy_last);
    for (int i = 0; i < DATA_LEN; i++)
      applyStimulus(1'b1, w[i], i == 0, (i == DATA_LEN - 1) ? rdy_last : rdy_mid);
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [DATA_LEN-1:0] w;
    bus.serial_valid = 1'b0;
    bus.serial_in    = 1'b0;
    bus.frame_start  = 1'b0;
    bus.out_ready    = 1'b0;
    m_acc = '0; m_out = '0; m_idx = 0;
    m_busy = 1'b0; m_valid = 1'b0; m_ferr = 1'b0; m_over = 1'b0;

    $display("[TB] reset state");
    resetPulse();
    checkValue("reset_parallel_out", 64'(bus.parallel_out), 64'h0);
    checkValue("reset_out_valid", 64'(bus.out_valid), 64'h0);

    $display("[TB] basic frame 8'hA5");
    sendWord(8'hA5, 1'b1, 1'b1);
    checkValue("basic_word", 64'(bus.parallel_out), 64'hA5);
    checkValue("basic_valid", 64'(bus.out_valid), 64'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("basic_valid_drop", 64'(bus.out_valid), 64'h0);

    $display("[TB] gapped frame");
    w = 8'hA5;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, w[i], i == 0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    checkValue("gap_busy_hold", 64'(bus.busy), 64'h1);
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, w[i], 1'b0, 1'b1);
    checkValue("gap_word", 64'(bus.parallel_out), 64'hA5);
    checkValue("gap_no_ferr", 64'(bus.frame_err), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] backpressure and overrun");
    sendWord(8'h3C, 1'b0, 1'b0);
    sendWord(8'hC3, 1'b0, 1'b0);
    checkValue("bp_word_kept", 64'(bus.parallel_out), 64'h3C);
    checkValue("bp_overrun", 64'(bus.overrun), 64'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("bp_consumed", 64'(bus.out_valid), 64'h0);
    checkValue("bp_overrun_sticky", 64'(bus.overrun), 64'h1);

    $display("[TB] consume and complete");
    resetPulse();
    sendWord(8'h11, 1'b0, 1'b0);
    sendWord(8'h22, 1'b0, 1'b1);
    checkValue("cc_word", 64'(bus.parallel_out), 64'h22);
    checkValue("cc_valid", 64'(bus.out_valid), 64'h1);
    checkValue("cc_no_overrun", 64'(bus.overrun), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] resync");
    w = 8'h96;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, w[i], i == 0, 1'b1);
    w = 8'h5A;
    applyStimulus(1'b1, w[0], 1'b1, 1'b1);
    checkValue("resync_ferr", 64'(bus.frame_err), 64'h1);
    checkValue("resync_no_word", 64'(bus.out_valid), 64'h0);
    for (int i = 1; i < 8; i++) applyStimulus(1'b1, w[i], 1'b0, 1'b1);
    checkValue("resync_word", 64'(bus.parallel_out), 64'h5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset mid-frame");
    sendWord(8'h77, 1'b0, 1'b0);
    w = 8'hE1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, w[i], i == 0, 1'b0);
    resetPulse();
    checkValue("rmf_valid", 64'(bus.out_valid), 64'h0);
    checkValue("rmf_busy", 64'(bus.busy), 64'h0);
    checkValue("rmf_word", 64'(bus.parallel_out), 64'h0);
    sendWord(8'hFF, 1'b0, 1'b0);
    checkValue("rmf_next_word", 64'(bus.parallel_out), 64'hFF);

    $display("[TB] random traffic");
    resetPulse();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Receive-end counterpart of the parallel-to-serial shifter.
- Reassembles LSB-first serial frames of DATA_LEN bits into parallel words.
- Presents each word on a valid/ready output port.
- Sits at the sink of the serial link and detects framing resyncs and output overruns.

Parameters:
DATA_LEN, 8, bits per frame and width of parallel_out; legal range 2..64

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
serial_in  input  1  serial data bit, LSB of the word first
serial_valid  input  1  serial_in carries a valid bit this cycle; no shift when low
frame_start  input  1  qualified by serial_valid; marks bit 0 of a new frame
parallel_out  output  DATA_LEN  assembled word; stable while out_valid=1
out_valid  output  1  parallel_out holds an unconsumed word
out_ready  input  1  consumer accepts the word when out_valid && out_ready
busy  output  1  a frame is partially received (state SHIFT)
frame_err  output  1  one-cycle pulse: frame_start arrived mid-frame
overrun  output  1  sticky: a completed word was dropped because the output was full

Behaviour:
- Reset (rst=1 at a clk edge) has priority over all other inputs.
  - state=IDLE, shift register=0, bit counter=0.
  - parallel_out=0, out_valid=0, busy=0, frame_err=0, overrun=0.
  - A reset mid-frame discards the partial frame and clears any pending word.
- Bit acceptance: a bit is accepted only on edges where serial_valid=1. Where serial_valid=0, shift register, counter and state hold.
- Shift rule: shreg <= {serial_in, shreg[DATA_LEN-1:1]}. After DATA_LEN accepted bits, the first-received bit sits in shreg[0].
- FSM:
  - IDLE:
    - serial_valid && frame_start: accept bit 0, counter=1, go to SHIFT.
    - serial_valid && !frame_start: bit ignored, stay IDLE.
  - SHIFT:
    - Each accepted bit increments the counter.
    - On the bit that makes counter==DATA_LEN: word complete, counter=0, go to IDLE.
    - serial_valid && frame_start in SHIFT: resync.
      - Discard the partial frame.
      - The current bit is taken as bit 0 of the new frame; counter=1; stay SHIFT.
      - frame_err=1 for exactly the next cycle.
- busy=1 exactly while state=SHIFT.
- Word completion, evaluated on the edge that accepts the last bit:
  - Output empty (out_valid=0), or the word is being consumed this edge (out_valid && out_ready): parallel_out <= completed word, out_valid=1.
  - Latency: parallel_out and out_valid update on the same edge that samples the last bit. They are visible the cycle after the last bit is presented.
  - Output full and not consumed (out_valid && !out_ready): the new word is dropped, parallel_out unchanged, overrun <= 1. overrun stays set until rst.
- Output handshake:
  - out_valid && out_ready at an edge with no word completing: out_valid <= 0. parallel_out holds its last value.
  - parallel_out never changes while out_valid=1 && out_ready=0.
  - out_ready while out_valid=0 has no effect.
- Simultaneous events:
  - Consume and complete on the same edge: the new word is loaded, out_valid stays 1, no overrun.
  - Completion and frame_start on the same edge as the last bit in SHIFT: frame_start wins. This is a resync; no word is produced.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Basic frame: DATA_LEN=8, out_ready=1; frame_start with bits 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles -> parallel_out=8'hA5, out_valid=1 for 1 cycle starting the cycle after bit 7; busy=1 during bits 1..7.
- Gapped input: same 8'hA5 frame with serial_valid low for 3 cycles between bit 3 and bit 4 -> parallel_out=8'hA5, out_valid rising 3 cycles later than in the basic frame; no frame_err.
- Backpressure/overrun: out_ready=0; send 8'h3C then 8'hC3 -> parallel_out stays 8'h3C, out_valid=1, overrun=1 after the 2nd frame; raising out_ready for 1 cycle -> out_valid=0, overrun remains 1.
- Consume-and-complete: out_valid=1 with 8'h11; out_ready pulsed on the same edge the 8'h22 frame's last bit is accepted -> parallel_out=8'h22, out_valid=1 continuously, overrun=0.
- Resync: frame_start after 4 bits of a frame, then a full 8'h5A frame starting at that bit -> frame_err pulses 1 cycle, output 8'h5A only (the partial frame is never output).
- Reset mid-frame: rst=1 for 1 cycle after 5 bits, with a pending word out_valid=1 -> out_valid=0, busy=0, overrun=0, parallel_out=0; the next complete 8'hFF frame -> parallel_out=8'hFF.
